// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the shared multicycle datapath. Every control output is
// registered from the next state, except the branch PC enable and the illegal pulse.
module multicycle_ctrl #(
  parameter int OP_W  = 6,
  parameter int FN_W  = 6,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  opcode,
  input  logic [FN_W-1:0]  funct,
  input  logic             zero,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [SEL_W-1:0] alu_sel,
  output logic             illegal,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    INIT    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEM_ADR = 4'd3,
    MEM_RD  = 4'd4,
    MEM_WB  = 4'd5,
    MEM_WR  = 4'd6,
    EXEC_R  = 4'd7,
    R_WB    = 4'd8,
    EXEC_I  = 4'd9,
    I_WB    = 4'd10,
    BRANCH  = 4'd11,
    JUMP    = 4'd12
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'h05);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'h0C);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'h0D);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);

  localparam logic [FN_W-1:0] FN_SLL  = FN_W'(6'h00);
  localparam logic [FN_W-1:0] FN_SRL  = FN_W'(6'h02);
  localparam logic [FN_W-1:0] FN_MULT = FN_W'(6'h18);
  localparam logic [FN_W-1:0] FN_ADD  = FN_W'(6'h20);
  localparam logic [FN_W-1:0] FN_SUB  = FN_W'(6'h22);
  localparam logic [FN_W-1:0] FN_AND  = FN_W'(6'h24);
  localparam logic [FN_W-1:0] FN_OR   = FN_W'(6'h25);
  localparam logic [FN_W-1:0] FN_NOR  = FN_W'(6'h27);
  localparam logic [FN_W-1:0] FN_SLT  = FN_W'(6'h2A);

  localparam logic [SEL_W-1:0] ALU_ADD = SEL_W'(4'd0);
  localparam logic [SEL_W-1:0] ALU_AND = SEL_W'(4'd1);
  localparam logic [SEL_W-1:0] ALU_OR  = SEL_W'(4'd2);
  localparam logic [SEL_W-1:0] ALU_NOR = SEL_W'(4'd3);
  localparam logic [SEL_W-1:0] ALU_SLT = SEL_W'(4'd4);
  localparam logic [SEL_W-1:0] ALU_SLL = SEL_W'(4'd5);
  localparam logic [SEL_W-1:0] ALU_SRL = SEL_W'(4'd6);
  localparam logic [SEL_W-1:0] ALU_SUB = SEL_W'(4'd7);
  localparam logic [SEL_W-1:0] ALU_MUL = SEL_W'(4'd8);

  function automatic logic funct_ok(input logic [FN_W-1:0] f);
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR,
      FN_SLT, FN_MULT, FN_SLL, FN_SRL: funct_ok = 1'b1;
      default:                         funct_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [SEL_W-1:0] r_alu_sel(input logic [FN_W-1:0] f);
    case (f)
      FN_SUB:  r_alu_sel = ALU_SUB;
      FN_AND:  r_alu_sel = ALU_AND;
      FN_OR:   r_alu_sel = ALU_OR;
      FN_NOR:  r_alu_sel = ALU_NOR;
      FN_SLT:  r_alu_sel = ALU_SLT;
      FN_MULT: r_alu_sel = ALU_MUL;
      FN_SLL:  r_alu_sel = ALU_SLL;
      FN_SRL:  r_alu_sel = ALU_SRL;
      default: r_alu_sel = ALU_ADD;
    endcase
  endfunction

  state_t           state;
  state_t           next_state;
  logic             decode_ok;
  logic             pc_en_q;
  logic             bne_q;

  logic             nx_pc_en;
  logic             nx_iord;
  logic             nx_mem_write;
  logic             nx_ir_write;
  logic             nx_reg_dst;
  logic             nx_mem_to_reg;
  logic             nx_reg_write;
  logic [1:0]       nx_src_a;
  logic [1:0]       nx_src_b;
  logic [1:0]       nx_pc_src;
  logic [SEL_W-1:0] nx_alu_sel;
  logic             nx_bne;

  always_comb begin
    decode_ok = 1'b0;
    case (opcode)
      OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ANDI, OP_ORI, OP_J: decode_ok = 1'b1;
      OP_RTYPE:                       decode_ok = funct_ok(funct);
      default:                        decode_ok = 1'b0;
    endcase
  end

  always_comb begin
    next_state = INIT;
    case (state)
      INIT:    next_state = FETCH;
      FETCH:   next_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:          next_state = MEM_ADR;
          OP_RTYPE:              next_state = funct_ok(funct) ? EXEC_R : FETCH;
          OP_BEQ, OP_BNE:        next_state = BRANCH;
          OP_ADDI, OP_ANDI,
          OP_ORI:                next_state = EXEC_I;
          OP_J:                  next_state = JUMP;
          default:               next_state = FETCH;
        endcase
      end
      MEM_ADR: next_state = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:  next_state = MEM_WB;
      MEM_WB:  next_state = FETCH;
      MEM_WR:  next_state = FETCH;
      EXEC_R:  next_state = R_WB;
      R_WB:    next_state = FETCH;
      EXEC_I:  next_state = I_WB;
      I_WB:    next_state = FETCH;
      BRANCH:  next_state = FETCH;
      JUMP:    next_state = FETCH;
      default: next_state = INIT;
    endcase
  end

  // Controls for the state being entered; opcode/funct are still those of the
  // IR loaded in FETCH, so EXEC_R/EXEC_I selects can be resolved at the DECODE edge.
  always_comb begin
    nx_pc_en      = 1'b0;
    nx_iord       = 1'b0;
    nx_mem_write  = 1'b0;
    nx_ir_write   = 1'b0;
    nx_reg_dst    = 1'b0;
    nx_mem_to_reg = 1'b0;
    nx_reg_write  = 1'b0;
    nx_src_a      = 2'b00;
    nx_src_b      = 2'b00;
    nx_pc_src     = 2'b00;
    nx_alu_sel    = ALU_ADD;
    nx_bne        = 1'b0;
    case (next_state)
      FETCH: begin
        nx_ir_write = 1'b1;
        nx_src_b    = 2'b01;
        nx_pc_en    = 1'b1;
      end
      DECODE:  nx_src_b = 2'b11;
      MEM_ADR: begin
        nx_src_a = 2'b01;
        nx_src_b = 2'b10;
      end
      MEM_RD:  nx_iord = 1'b1;
      MEM_WB: begin
        nx_mem_to_reg = 1'b1;
        nx_reg_write  = 1'b1;
      end
      MEM_WR: begin
        nx_iord      = 1'b1;
        nx_mem_write = 1'b1;
      end
      EXEC_R: begin
        nx_alu_sel = r_alu_sel(funct);
        if (funct == FN_SLL || funct == FN_SRL) begin
          nx_src_a = 2'b10;
          nx_src_b = 2'b10;
        end else begin
          nx_src_a = 2'b01;
          nx_src_b = 2'b00;
        end
      end
      R_WB: begin
        nx_reg_dst   = 1'b1;
        nx_reg_write = 1'b1;
      end
      EXEC_I: begin
        nx_src_a = 2'b01;
        nx_src_b = 2'b10;
        if (opcode == OP_ANDI)     nx_alu_sel = ALU_AND;
        else if (opcode == OP_ORI) nx_alu_sel = ALU_OR;
        else                       nx_alu_sel = ALU_ADD;
      end
      I_WB:    nx_reg_write = 1'b1;
      BRANCH: begin
        nx_src_a   = 2'b01;
        nx_src_b   = 2'b00;
        nx_alu_sel = ALU_SUB;
        nx_pc_src  = 2'b01;
        nx_bne     = (opcode == OP_BNE);
      end
      JUMP: begin
        nx_pc_src = 2'b10;
        nx_pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= INIT;
      pc_en_q    <= 1'b0;
      iord       <= 1'b0;
      mem_write  <= 1'b0;
      ir_write   <= 1'b0;
      reg_dst    <= 1'b0;
      mem_to_reg <= 1'b0;
      reg_write  <= 1'b0;
      alu_src_a  <= 2'b00;
      alu_src_b  <= 2'b00;
      pc_src     <= 2'b00;
      alu_sel    <= ALU_ADD;
      bne_q      <= 1'b0;
    end else begin
      state      <= next_state;
      pc_en_q    <= nx_pc_en;
      iord       <= nx_iord;
      mem_write  <= nx_mem_write;
      ir_write   <= nx_ir_write;
      reg_dst    <= nx_reg_dst;
      mem_to_reg <= nx_mem_to_reg;
      reg_write  <= nx_reg_write;
      alu_src_a  <= nx_src_a;
      alu_src_b  <= nx_src_b;
      pc_src     <= nx_pc_src;
      alu_sel    <= nx_alu_sel;
      bne_q      <= nx_bne;
    end
  end

  // The branch decision needs the live zero flag from the SUB in this cycle.
  assign pc_en   = pc_en_q | ((state == BRANCH) && (zero ^ bne_q));
  assign illegal = (state == DECODE) && !decode_ok;
  assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction vector table feeding a
// scoreboard of per-cycle expected controls, plus reset corner sequences.
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic [1:0] alu_src_a, alu_src_b, pc_src;
  logic [3:0] alu_sel;
  logic       illegal;
  logic [3:0] state_o;

  multicycle_ctrl #(.OP_W(6), .FN_W(6), .SEL_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .pc_en      (pc_en),
    .iord       (iord),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alu_sel    (alu_sel),
    .illegal    (illegal),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] pc_src;
    logic [3:0] alu_sel;
    logic       illegal;
  } ctl_t;

  typedef struct {
    string       label;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    int          ncyc;
    logic [19:0] states;
    logic [3:0]  exec_sel;
    logic        shift;
    logic        bad;
    logic        taken;
  } vec_t;

  vec_t tbl[$];
  ctl_t exp_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  function automatic vec_t mk(input string l, input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input int n, input logic [19:0] st,
                              input logic [3:0] sel, input logic sh, input logic bad,
                              input logic tk);
    vec_t v;
    v.label = l; v.opcode = op; v.funct = fn; v.zero = z; v.ncyc = n; v.states = st;
    v.exec_sel = sel; v.shift = sh; v.bad = bad; v.taken = tk;
    return v;
  endfunction

  // Expected controls written directly from the state table of the controller.
  function automatic ctl_t expCtl(input logic [3:0] st, input vec_t v);
    ctl_t c;
    c = '0;
    c.state = st;
    case (st)
      4'd1:  begin c.ir_write = 1'b1; c.src_b = 2'b01; c.pc_en = 1'b1; end
      4'd2:  begin c.src_b = 2'b11; c.illegal = v.bad; end
      4'd3:  begin c.src_a = 2'b01; c.src_b = 2'b10; end
      4'd4:  c.iord = 1'b1;
      4'd5:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      4'd6:  begin c.iord = 1'b1; c.mem_write = 1'b1; end
      4'd7:  begin
        c.alu_sel = v.exec_sel;
        c.src_a   = v.shift ? 2'b10 : 2'b01;
        c.src_b   = v.shift ? 2'b10 : 2'b00;
      end
      4'd8:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      4'd9:  begin c.src_a = 2'b01; c.src_b = 2'b10; c.alu_sel = v.exec_sel; end
      4'd10: c.reg_write = 1'b1;
      4'd11: begin c.src_a = 2'b01; c.alu_sel = 4'b0111; c.pc_src = 2'b01; c.pc_en = v.taken; end
      4'd12: begin c.pc_src = 2'b10; c.pc_en = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic applyStimulus(input vec_t v);
    opcode = v.opcode;
    funct  = v.funct;
    zero   = v.zero;
    for (int c = 0; c < v.ncyc; c++)
      exp_q.push_back(expCtl(v.states[19-4*c -: 4], v));
  endtask

  task automatic checkOutput(input string name);
    ctl_t act;
    ctl_t want;
    #1;
    act = {state_o, pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, pc_src, alu_sel, illegal};
    n_compared++;
    if (exp_q.size() == 0) begin
      n_mismatched++;
      $display("[TB] FAIL %s: no expected entry, actual ctl=%h state=%0d", name, act, state_o);
    end else begin
      want = exp_q.pop_front();
      if (act !== want) begin
        n_mismatched++;
        $display("[TB] FAIL %s: actual ctl=%h (state %0d sel %b pc_en %b) required ctl=%h (state %0d sel %b pc_en %b)",
                 name, act, act.state, act.alu_sel, act.pc_en,
                 want, want.state, want.alu_sel, want.pc_en);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;
    rst = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0;

    tbl.push_back(mk("lw",      6'h23, 6'h01, 1'b0, 5, {4'd1,4'd2,4'd3,4'd4,4'd5}, 4'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("sw",      6'h2B, 6'h01, 1'b0, 4, {4'd1,4'd2,4'd3,4'd6,4'd0}, 4'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("add",     6'h00, 6'h20, 1'b0, 4, {4'd1,4'd2,4'd7,4'd8,4'd0}, 4'b0000, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("sub",     6'h00, 6'h22, 1'b0, 4, {4'd1,4'd2,4'd7,4'd8,4'd0}, 4'b0111, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("and",     6'h00, 6'h24, 1'b0, 4, {4'd1,4'd2,4'd7,4'd8,4'd0}, 4'b0001, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("or",      6'h00, 6'h25, 1'b0, 4, {4'd1,4'd2,4'd7,4'd8,4'd0}, 4'b0010, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("nor",     6'h00, 6'h27, 1'b0, 4, {4'd1,4'd2,4'd7,4'd8,4'd0}, 4'b0011, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("slt",     6'h00, 6'h2A, 1'b0, 4, {4'd1,4'd2,4'd7,4'd8,4'd0}, 4'b0100, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("mult",    6'h00, 6'h18, 1'b0, 4, {4'd1,4'd2,4'd7,4'd8,4'd0}, 4'b1000, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("sll",     6'h00, 6'h00, 1'b0, 4, {4'd1,4'd2,4'd7,4'd8,4'd0}, 4'b0101, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk("srl",     6'h00, 6'h02, 1'b0, 4, {4'd1,4'd2,4'd7,4'd8,4'd0}, 4'b0110, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk("addi",    6'h08, 6'h01, 1'b0, 4, {4'd1,4'd2,4'd9,4'd10,4'd0}, 4'b0000, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("andi",    6'h0C, 6'h01, 1'b0, 4, {4'd1,4'd2,4'd9,4'd10,4'd0}, 4'b0001, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("ori",     6'h0D, 6'h01, 1'b0, 4, {4'd1,4'd2,4'd9,4'd10,4'd0}, 4'b0010, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("beq_z1",  6'h04, 6'h01, 1'b1, 3, {4'd1,4'd2,4'd11,4'd0,4'd0}, 4'd0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk("beq_z0",  6'h04, 6'h01, 1'b0, 3, {4'd1,4'd2,4'd11,4'd0,4'd0}, 4'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("bne_z1",  6'h05, 6'h01, 1'b1, 3, {4'd1,4'd2,4'd11,4'd0,4'd0}, 4'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("bne_z0",  6'h05, 6'h01, 1'b0, 3, {4'd1,4'd2,4'd11,4'd0,4'd0}, 4'd0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk("j",       6'h02, 6'h01, 1'b0, 3, {4'd1,4'd2,4'd12,4'd0,4'd0}, 4'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("ill_op",  6'h3F, 6'h20, 1'b0, 2, {4'd1,4'd2,4'd0,4'd0,4'd0}, 4'd0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk("ill_fn",  6'h00, 6'h01, 1'b0, 2, {4'd1,4'd2,4'd0,4'd0,4'd0}, 4'd0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk("lw_b2b",  6'h23, 6'h20, 1'b1, 5, {4'd1,4'd2,4'd3,4'd4,4'd5}, 4'd0, 1'b0, 1'b0, 1'b0));

    // Power-on reset: INIT with every output low.
    @(negedge clk); @(negedge clk);
    exp_q.push_back(expCtl(4'd0, tbl[0]));
    checkOutput("reset_init");
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    exp_q.push_back(expCtl(4'd1, tbl[0]));
    checkOutput("fetch_after_reset");

    // Instruction stream, back to back, each starting in FETCH.
    foreach (tbl[i]) begin
      v = tbl[i];
      applyStimulus(v);
      for (int c = 0; c < v.ncyc; c++) begin
        checkOutput($sformatf("%s_c%0d", v.label, c));
        @(posedge clk); @(negedge clk);
      end
    end

    // Reset asserted in the middle of a load, while in MEM_RD.
    v = tbl[0];
    opcode = v.opcode; funct = v.funct; zero = v.zero;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
    end
    exp_q.push_back(expCtl(4'd4, v));
    checkOutput("mid_mem_rd");
    #2 rst = 1'b1;
    exp_q.push_back(expCtl(4'd0, v));
    checkOutput("async_reset_now");
    @(posedge clk); @(negedge clk);
    exp_q.push_back(expCtl(4'd0, v));
    checkOutput("reset_held");
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    exp_q.push_back(expCtl(4'd1, v));
    checkOutput("fetch_after_mid_reset");

    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL scoreboard_drain: actual %0d leftover entries, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
